// File: rtl/output_mem_read_arbiter.sv
// Round-robin arbiter sharing the output image memory read port between CPU readback (0) and result streamer (1).
// Latency: request accept edge to rsp_valid is 3 cycles; one transaction in flight, so at best one accept every 4 cycles.
// Backpressure: the response is held in RESPOND until the winner's rsp_ready; no request is accepted meanwhile.
module output_mem_read_arbiter #(
    parameter int ADD_SIZE  = 11,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [ADD_SIZE-1:0]  req0_addr,
    output logic                 req0_ready,
    output logic                 rsp0_valid,
    output logic [DATA_SIZE-1:0] rsp0_data,
    input  logic                 rsp0_ready,
    input  logic                 req1_valid,
    input  logic [ADD_SIZE-1:0]  req1_addr,
    output logic                 req1_ready,
    output logic                 rsp1_valid,
    output logic [DATA_SIZE-1:0] rsp1_data,
    input  logic                 rsp1_ready,
    output logic                 read_en_out,
    output logic [ADD_SIZE-1:0]  address_out,
    input  logic [DATA_SIZE-1:0] mem_data_in,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   winner_q, winner_d;
    logic [ADD_SIZE-1:0]    addr_q, addr_d;
    logic [DATA_SIZE-1:0]   rsp0_data_q, rsp0_data_d;
    logic [DATA_SIZE-1:0]   rsp1_data_q, rsp1_data_d;
    logic                   grant0, grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            addr_q       <= '0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            addr_q       <= addr_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        addr_d       = addr_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        // last_grant_q==1 means requester 1 was served last, so 0 wins a tie
        grant0       = req0_valid & (~req1_valid | last_grant_q);
        grant1       = req1_valid & (~req0_valid | ~last_grant_q);

        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0) begin
                    addr_d       = req0_addr;
                    winner_d     = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = ISSUE;
                end else if (grant1) begin
                    addr_d       = req1_addr;
                    winner_d     = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (winner_q) begin
                    rsp1_data_d = mem_data_in;
                end else begin
                    rsp0_data_d = mem_data_in;
                end
                state_d = RESPOND;
            end
            RESPOND: begin
                if (winner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign read_en_out = (state_q == ISSUE);
    assign address_out = addr_q;
    assign rsp0_valid  = (state_q == RESPOND) & ~winner_q;
    assign rsp1_valid  = (state_q == RESPOND) &  winner_q;
    assign rsp0_data   = rsp0_data_q;
    assign rsp1_data   = rsp1_data_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_output_mem_read_arbiter.sv
// Scoreboard bench for output_mem_read_arbiter: accepted requests queue expected issue addresses and response data.
module tb_output_mem_read_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          rsp0_ready, rsp1_ready;
    logic          read_en_out;
    logic [AW-1:0] address_out;
    logic [DW-1:0] mem_data_in;
    logic          busy;

    output_mem_read_arbiter #(.ADD_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .read_en_out(read_en_out), .address_out(address_out),
        .mem_data_in(mem_data_in), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    int n_acc = 0;
    int n_rd  = 0;

    logic [DW:0]   exp_q[$];
    logic [AW-1:0] iss_q[$];
    int            glog_id[$];
    logic [AW-1:0] glog_addr[$];
    int            glog_cyc[$];

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 11'h010) return 32'hDEADBEEF;
        return {5'h15, a, ~a[4:0], a};
    endfunction

    // Memory answers one cycle after read_en_out; junk otherwise so a mistimed capture shows up
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_data_in <= read_en_out ? mem_fn(address_out) : (32'hBAD00000 | 32'(cyc[15:0]));
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic accept(input int id, input logic [AW-1:0] a);
        exp_q.push_back({id[0], mem_fn(a)});
        iss_q.push_back(a);
        glog_id.push_back(id);
        glog_addr.push_back(a);
        glog_cyc.push_back(cyc);
        n_acc++;
    endtask

    task automatic resp(input int id, input logic [DW-1:0] d);
        logic [DW:0] e;
        chk("rsp_pending", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("rsp%0d_id", id), 64'(id), 64'(e[DW]));
            chk($sformatf("rsp%0d_data", id), d, e[DW-1:0]);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            iss_q.delete();
        end else begin
            chk("ready_onehot", req0_ready & req1_ready, 0);
            chk("rsp_onehot", rsp0_valid & rsp1_valid, 0);
            if (req0_valid && req0_ready) accept(0, req0_addr);
            if (req1_valid && req1_ready) accept(1, req1_addr);
            if (read_en_out) begin
                n_rd++;
                chk("issue_pending", 64'(iss_q.size() > 0), 1);
                if (iss_q.size() > 0) chk("issue_addr", address_out, iss_q.pop_front());
            end
            if (rsp0_valid && rsp0_ready) resp(0, rsp0_data);
            if (rsp1_valid && rsp1_ready) resp(1, rsp1_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {req0_ready, req1_ready, rsp0_valid, rsp1_valid, read_en_out, busy}, 0);
        chk({tag, "_addr"}, address_out, 0);
        chk({tag, "_d0"}, rsp0_data, 0);
        chk({tag, "_d1"}, rsp1_data, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero("rst");
        tick();
        rst = 1'b0;
        glog_id.delete();
        glog_addr.delete();
        glog_cyc.delete();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (busy || rsp0_valid || rsp1_valid); i++) @(negedge clk);
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_q_empty"}, 64'(exp_q.size()), 0);
        chk({tag, "_rd_per_acc"}, 64'(n_rd), 64'(n_acc));
    endtask

    task automatic wait_grants(input int n);
        for (int i = 0; i < 60 && glog_id.size() < n; i++) @(negedge clk);
        chk("grants_seen", 64'(glog_id.size() >= n), 1);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // 1: single read, cycle-accurate timing
        do_reset();
        req0_addr = 11'h010;
        req0_valid = 1'b1;
        @(negedge clk);
        chk("t1_c0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_c1_rden", read_en_out, 1);
        chk("t1_c1_addr", address_out, 11'h010);
        @(negedge clk);
        chk("t1_c2_rden", read_en_out, 0);
        @(negedge clk);
        chk("t1_c3_valid", rsp0_valid, 1);
        chk("t1_c3_data", rsp0_data, 32'hDEADBEEF);
        chk("t1_c3_rsp1", rsp1_valid, 0);
        drain("t1");

        // 2: continuous contention alternates, 4-cycle spacing
        do_reset();
        req0_addr = 11'h001; req1_addr = 11'h002;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grants(4);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("t2");
        for (int k = 0; k < 4; k++) begin
            chk("t2_id", 64'(glog_id[k]), 64'(k % 2));
            chk("t2_addr", glog_addr[k], (k % 2 == 1) ? 11'h002 : 11'h001);
            if (k > 0) chk("t2_gap", 64'(glog_cyc[k] - glog_cyc[k-1]), 4);
        end

        // 3: lone requester 1 gets back-to-back grants
        do_reset();
        req1_addr = 11'h7FF;
        req1_valid = 1'b1;
        wait_grants(4);
        tick();
        req1_valid = 1'b0;
        drain("t3");
        for (int k = 0; k < 4; k++) begin
            chk("t3_id", 64'(glog_id[k]), 1);
            chk("t3_addr", glog_addr[k], 11'h7FF);
        end

        // 4: response backpressure holds data, blocks the other requester
        do_reset();
        req0_addr = 11'h020; req1_addr = 11'h030;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("t4_acc0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 20 && !rsp0_valid; i++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", rsp0_valid, 1);
            chk("t4_hold_data", rsp0_data, mem_fn(11'h020));
            chk("t4_busy", busy, 1);
            chk("t4_req1_blocked", req1_ready, 0);
            @(negedge clk);
        end
        tick();
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("t4_hs_req1_blocked", req1_ready, 0);
        chk("t4_hs_valid", rsp0_valid, 1);
        @(negedge clk);
        chk("t4_req1_accept", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        drain("t4");
        chk("t4_order", 64'({glog_id.size() == 2, glog_id[0] == 0, glog_id[1] == 1}), 3'b111);

        // 5: reset during CAPTURE aborts, then requester 0 wins contention again
        do_reset();
        req0_addr = 11'h040;
        req0_valid = 1'b1;
        @(negedge clk);
        chk("t5_acc0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_zero("t5_abort");
        tick();
        req0_addr = 11'h060; req1_addr = 11'h061;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("t5_req0_wins", req0_ready, 1);
        chk("t5_req1_loses", req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("t5");

        // 6: a short req0 pulse during requester 1's RESPOND is not accepted
        do_reset();
        rsp1_ready = 1'b0;
        req1_addr = 11'h070;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("t6_acc1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 20 && !rsp1_valid; i++) @(negedge clk);
        chk("t6_in_respond", rsp1_valid, 1);
        tick();
        req0_addr = 11'h071;
        req0_valid = 1'b1;
        @(negedge clk);
        chk("t6_pulse_ignored", req0_ready, 0);
        tick();
        req0_valid = 1'b0;
        rsp1_ready = 1'b1;
        drain("t6");
        chk("t6_one_grant", 64'(glog_id.size()), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule
